// File: rtl/alu_regfile_sequencer_if.sv
// Op-request and result handshake bundle between the issue client and the
// ALU register-file sequencer.
interface alu_regfile_sequencer_if #(
    parameter int N  = 32,
    parameter int AW = 4
);
    // Op request (client -> sequencer)
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_cmd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [AW-1:0] in_rd;

    // Result (sequencer -> client)
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_rd;
    logic [N-1:0]  out_data;

    // Client side: issues ops, consumes results
    modport master (
        output in_valid, in_cmd, in_rs1, in_rs2, in_rd, out_ready,
        input  in_ready, out_valid, out_rd, out_data
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_cmd, in_rs1, in_rs2, in_rd, out_ready,
        output in_ready, out_valid, out_rd, out_data
    );
endinterface

// File: rtl/alu_regfile_sequencer.sv
// Operand/issue stage for an external combinational ALU: small register
// file, one op in flight, IDLE -> EXEC -> RESP with writeback of the ALU
// result before the next op can be accepted.
module alu_regfile_sequencer #(
    parameter int N    = 32,
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_en,
    input  logic [AW-1:0]             ld_addr,
    input  logic [N-1:0]              ld_data,
    alu_regfile_sequencer_if.slave    bus,
    output logic [N-1:0]              alu_a,
    output logic [N-1:0]              alu_b,
    output logic [3:0]                alu_cmd,
    input  logic [N-1:0]              alu_z,
    input  logic [AW-1:0]             dbg_addr,
    output logic [N-1:0]              dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [NREG-1:0][N-1:0]   rf;
    logic [N-1:0]             rs1_val, rs2_val;
    logic                     accept;
    logic                     ld_we, wb_we;
    logic                     out_valid_q;
    logic [AW-1:0]            out_rd_q;
    logic [N-1:0]             out_data_q;

    // Loads take priority over ops so a client never races its own preload.
    assign bus.in_ready = (state_q == IDLE) && !ld_en;
    assign accept       = bus.in_valid && bus.in_ready;

    // R0 is hardwired to zero on every read port.
    assign rs1_val  = (bus.in_rs1 == '0) ? '0 : rf[bus.in_rs1];
    assign rs2_val  = (bus.in_rs2 == '0) ? '0 : rf[bus.in_rs2];
    assign dbg_data = (dbg_addr == '0)   ? '0 : rf[dbg_addr];

    // Write ports live in disjoint states, so they never collide.
    assign ld_we = (state_q == IDLE) && ld_en && (ld_addr != '0);
    assign wb_we = (state_q == EXEC) && (out_rd_q != '0);

    assign bus.out_valid = out_valid_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_data  = out_data_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: EXEC is a single cycle; RESP waits for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = EXEC;
            EXEC:                       state_d = RESP;
            RESP:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Register file: preload in IDLE, ALU writeback at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rf <= '0;
        else if (ld_we) rf[ld_addr]  <= ld_data;
        else if (wb_we) rf[out_rd_q] <= alu_z;
    end

    // Operand/command capture on accept; result capture and release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cmd     <= '0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a    <= rs1_val;
                        alu_b    <= rs2_val;
                        alu_cmd  <= bus.in_cmd;
                        out_rd_q <= bus.in_rd;
                    end
                end
                EXEC: begin
                    out_data_q  <= alu_z;
                    out_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// Directed bench for alu_regfile_sequencer with a small behavioural ALU
// (0=ADD, 1=SUB, others XOR) closing the loop on alu_z.
module tb_alu_regfile_sequencer;

    localparam int N    = 32;
    localparam int NREG = 16;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [N-1:0]  ld_data;
    logic [N-1:0]  alu_a, alu_b, alu_z;
    logic [3:0]    alu_cmd;
    logic [AW-1:0] dbg_addr;
    logic [N-1:0]  dbg_data;

    int vectors    = 0;
    int miscompares = 0;

    alu_regfile_sequencer_if #(.N(N), .AW(AW)) bus ();

    alu_regfile_sequencer #(.N(N), .NREG(NREG), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cmd  (alu_cmd),
        .alu_z    (alu_z),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // External ALU model
    always_comb begin
        alu_z = alu_a ^ alu_b;
        case (alu_cmd)
            4'd0:    alu_z = alu_a + alu_b;
            4'd1:    alu_z = alu_a - alu_b;
            default: alu_z = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dbg(input string tag, input logic [AW-1:0] a, input logic [N-1:0] exp);
        dbg_addr = a;
        #0;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [N-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one op from IDLE and check fixed latency with out_ready high.
    task automatic run_op(input string tag, input logic [3:0] cmd, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                          input logic [N-1:0] exp_data);
        @(negedge clk);
        chk({tag, "_rdy_idle"}, N'(bus.in_ready), N'(1));
        bus.in_valid = 1'b1; bus.in_cmd = cmd;
        bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
        @(posedge clk); #1;
        chk({tag, "_cmd"}, N'(alu_cmd), N'(cmd));
        chk({tag, "_vld_exec"}, N'(bus.out_valid), N'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_vld"}, N'(bus.out_valid), N'(1));
        chk({tag, "_data"}, bus.out_data, exp_data);
        chk({tag, "_rd"}, N'(bus.out_rd), N'(rd));
        @(posedge clk); #1;
        chk({tag, "_vld_drop"}, N'(bus.out_valid), N'(0));
    endtask

    initial begin
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        bus.in_valid = 1'b0; bus.in_cmd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_rd = '0; bus.out_ready = 1'b1;
        #12;
        chk("rst_a", alu_a, '0);
        chk("rst_cmd", N'(alu_cmd), N'(0));
        chk("rst_vld", N'(bus.out_valid), N'(0));
        chk("rst_data", bus.out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", N'(bus.in_ready), N'(1));

        // 1: basic add
        load(4'd1, 32'd5);
        load(4'd2, 32'd3);
        dbg("t1_r1", 4'd1, 32'd5);
        run_op("t1_add", 4'd0, 4'd1, 4'd2, 4'd3, 32'd8);
        dbg("t1_r3", 4'd3, 32'd8);

        // 2: subtract wraps, then dependent op sees the writeback
        run_op("t2_sub", 4'd1, 4'd2, 4'd1, 4'd4, 32'hFFFF_FFFE);
        run_op("t2_dep", 4'd0, 4'd4, 4'd1, 4'd5, 32'd3);
        dbg("t2_r5", 4'd5, 32'd3);

        // 3: R0 is never written and reads as zero
        load(4'd0, 32'h1234);
        dbg("t3_r0_ld", 4'd0, '0);
        run_op("t3_rd0", 4'd0, 4'd1, 4'd2, 4'd0, 32'd8);
        dbg("t3_r0_wb", 4'd0, '0);
        run_op("t3_src0", 4'd0, 4'd0, 4'd2, 4'd6, 32'd3);
        chk("t3_a0", alu_a, '0);

        // 4: back-pressure in RESP; stray ld/in ignored while busy
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_cmd = 4'd1; bus.in_rs1 = 4'd1;
        bus.in_rs2 = 4'd2; bus.in_rd = 4'd7;
        @(negedge clk);
        bus.in_cmd = 4'd0; bus.in_rd = 4'd9;
        ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'hDEAD;
        @(posedge clk); #1;
        chk("t4_vld", N'(bus.out_valid), N'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t4_hold_vld", N'(bus.out_valid), N'(1));
            chk("t4_hold_data", bus.out_data, 32'd2);
            chk("t4_hold_rd", N'(bus.out_rd), N'(7));
            chk("t4_hold_rdy", N'(bus.in_ready), N'(0));
            chk("t4_hold_cmd", N'(alu_cmd), N'(1));
        end
        @(negedge clk);
        ld_en = 1'b0; bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_release", N'(bus.out_valid), N'(0));
        dbg("t4_r1_kept", 4'd1, 32'd5);
        dbg("t4_r7", 4'd7, 32'd2);
        run_op("t4_next", 4'd0, 4'd7, 4'd2, 4'd8, 32'd5);

        // 5: async reset in EXEC
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_cmd = 4'd0; bus.in_rs1 = 4'd1;
        bus.in_rs2 = 4'd2; bus.in_rd = 4'd3;
        @(posedge clk); #1;
        chk("t5_a_exec", alu_a, 32'd5);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_a", alu_a, '0);
        chk("t5_b", alu_b, '0);
        chk("t5_vld", N'(bus.out_valid), N'(0));
        chk("t5_data", bus.out_data, '0);
        dbg("t5_rf", 4'd1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_rdy", N'(bus.in_ready), N'(1));
        @(posedge clk); #1;
        chk("t5_no_stale", N'(bus.out_valid), N'(0));

        // 6: load and op in the same cycle -> load wins, op waits one cycle
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 4'd9; ld_data = 32'h55;
        bus.in_valid = 1'b1; bus.in_cmd = 4'd2; bus.in_rs1 = 4'd9;
        bus.in_rs2 = 4'd0; bus.in_rd = 4'd10;
        #1;
        chk("t6_rdy_ld", N'(bus.in_ready), N'(0));
        @(posedge clk); #1;
        chk("t6_not_acc", N'(alu_cmd), N'(0));
        dbg("t6_r9", 4'd9, 32'h55);
        @(negedge clk);
        ld_en = 1'b0;
        #1;
        chk("t6_rdy", N'(bus.in_ready), N'(1));
        @(posedge clk); #1;
        chk("t6_acc_cmd", N'(alu_cmd), N'(2));
        chk("t6_acc_a", alu_a, 32'h55);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_data", bus.out_data, 32'h55);
        chk("t6_rd", N'(bus.out_rd), N'(10));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
